// File: rtl/keccak_mask_pkg.sv
// Shared sizing helpers and share compression for the masked Keccak datapath.
// Share i of a bit is the XOR of expanded shares i*(d+1)+j over j.
package keccak_mask_pkg;

  // Widest masking order the compression helper supports.
  localparam int MAX_D    = 3;
  localparam int MAX_NSH  = MAX_D + 1;
  localparam int MAX_NEXP = MAX_NSH * MAX_NSH;

  function automatic int NSH(input int order);
    return order + 1;
  endfunction

  function automatic int NEXP(input int order);
    return (order + 1) ** 2;
  endfunction

  // Only bits below nsh*nsh of x are read, and only the low nsh bits of the result are meaningful.
  function automatic logic [MAX_NSH-1:0] compress_shares(input logic [MAX_NEXP-1:0] x,
                                                         input int nsh);
    logic [MAX_NSH-1:0] r;
    logic               bit_v;
    r = '0;
    for (int i = 0; i < MAX_NSH; i++) begin
      for (int j = 0; j < MAX_NSH; j++) begin
        bit_v = ^(x & (MAX_NEXP'(1) << (i * nsh + j)));
        if (i < nsh && j < nsh) r = r ^ (MAX_NSH'(bit_v) << i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_share_reg_stage.sv
// Generic elastic valid/ready register stage; data loads only on a handshake.
module keccak_share_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/keccak_share_compress.sv
// Registered compression of (d+1)^2 expanded chi shares back to d+1 shares per bit.
// Stage 1 is a bare register so recombination never sees glitching S-box outputs.
module keccak_share_compress
  import keccak_mask_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP(d)-1:0]   ap,
  input  logic [NEXP(d)-1:0]   bp,
  input  logic [NEXP(d)-1:0]   cp,
  input  logic [NEXP(d)-1:0]   dp,
  input  logic [NEXP(d)-1:0]   ep,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSH(d)-1:0]    a,
  output logic [NSH(d)-1:0]    b,
  output logic [NSH(d)-1:0]    c,
  output logic [NSH(d)-1:0]    e,
  output logic [NSH(d)-1:0]    dd
);

  localparam int NS = NSH(d);
  localparam int NE = NEXP(d);

  logic              v1;
  logic              ready2;
  logic [5*NE-1:0]   s1_q;
  logic [5*NS-1:0]   s2_d;
  logic [5*NS-1:0]   s2_q;
  logic [MAX_NEXP-1:0] exp_v;

  keccak_share_reg_stage #(.W(5*NE)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ep, dp, cp, bp, ap}),
    .out_valid (v1),
    .out_ready (ready2),
    .out_data  (s1_q)
  );

  always_comb begin
    s2_d  = '0;
    exp_v = '0;
    for (int k = 0; k < 5; k++) begin
      exp_v          = '0;
      exp_v[NE-1:0]  = s1_q[k*NE +: NE];
      s2_d[k*NS +: NS] = NS'(compress_shares(exp_v, NS));
    end
  end

  keccak_share_reg_stage #(.W(5*NS)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (ready2),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign a  = s2_q[0*NS +: NS];
  assign b  = s2_q[1*NS +: NS];
  assign c  = s2_q[2*NS +: NS];
  assign dd = s2_q[3*NS +: NS];
  assign e  = s2_q[4*NS +: NS];

endmodule

// File: doc/keccak_share_compress.md
# keccak_share_compress

Registered share-compression stage that pairs with the masked chi S-box `keccak_sbox` in the low-latency masked Keccak datapath. It accepts the (d+1)^2 expanded output shares per lane bit (ap..ep), stores them in a glitch-isolating register, then XOR-compresses them back to d+1 shares per bit. The result feeds the next round's linear layer. The block is a two-stage elastic valid/ready pipeline, so the round controller can stall it without losing or duplicating data.

## Interface
- `d`, 2, security order; d+1 input shares per bit, (d+1)^2 expanded shares per bit.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; it clears all state immediately, independent of `clk`.
- `in_valid`  in  1  expanded shares on ap..ep are valid.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `ap`, `bp`, `cp`, `dp`, `ep`  in  (d+1)^2 each  expanded shares; index i*(d+1)+j, with the same layout as `keccak_sbox` outputs.
- `out_valid`  out  1  compressed shares on a..e are valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `a`, `b`, `c`, `e`, `dd`  out  d+1 each  compressed shares of the five chi output bits (`dd` is the d-bit, named to avoid clashing with the parameter).

## Operation
- Stage 1 (S1): register `s1_q` (5*(d+1)^2 bits) plus valid flag `v1`.
  - It loads on `in_valid && in_ready`.
  - No logic sits between the input port and `s1_q`; a pure register is the glitch barrier required before any share recombination.
- Compression: for each of the five bits and each share i, the result is XOR over j=0..d of `s1_q[i*(d+1)+j]`.
  - The compression is purely combinational from `s1_q` and uses no fresh randomness.
  - Shares with different i are never mixed.
- Stage 2 (S2): register of the compressed 5*(d+1) bits plus valid flag `v2`; it drives a..e and `out_valid` directly from flops.
- Per-stage handshake:
  - `ready2 = !v2 || out_ready`.
  - `ready1 = !v1 || ready2`.
  - `in_ready = ready1`.
  - S2 loads when `v1 && ready2`; S1 loads when `in_valid && ready1`.
  - `v1` update: set on load; else clear when S2 takes the data.
  - `v2` update: set on load from S1; else clear on `out_ready`.
- Stall: when `out_valid && !out_ready`, S2 holds its value and `out_valid` stays high. S1 holds if full. `in_ready` drops only when both stages are full.
- Data registers load only on their handshake; they are never written with don't-care data.

## Timing
- Reset values: `v1`, `v2`, `s1_q`, S2 data and a..e are all 0. `out_valid` is 0. `in_ready` is 1 after reset, as a combinational function of the cleared flags.
- Latency: input accepted at edge N appears on the outputs after edge N+1 (2 registers). Throughput is one item per cycle when `out_ready` stays high.
- Full pipeline with `out_ready`=1 and `in_valid`=1: S2 takes S1 and S1 takes the new input on the same edge (pass-through, no bubble).
- Full pipeline with `out_ready`=0: `in_ready`=0 and no state changes.
- Reset asserted mid-transfer: both stages empty and data clears to 0 asynchronously. In-flight items are dropped, and nothing is emitted after deassertion.
- The input is combinational-to-`in_ready` only through `out_ready`. There is no combinational path from any data input to any output.

## Structure
- Package `keccak_mask_pkg` holds:
  - `NSH(d) = d+1` and `NEXP(d) = (d+1)**2`.
  - The compression function `compress_shares` (NEXP bits to NSH bits), shared with future round-level compression.
- Sub-module `keccak_share_reg_stage`: a generic elastic register stage (parameter `W`; ports `clk`, `rst_n`, valid/ready/data in and out). It is instantiated twice, with `W` = 5*NEXP and `W` = 5*NSH.

## Test plan
- Reset then idle (d=2) -> `in_ready`=1, `out_valid`=0, a..e = 3'b000.
- Send `ap`=9'b000_000_111 and the rest 0, with `out_ready`=1 -> two edges later `a`=3'b001 and all other outputs 0, with `out_valid` high for exactly 1 cycle.
- Send `bp`=9'b011_101_110 -> `b`=3'b000; then `bp`=9'b100_010_001 -> `b`=3'b111.
- Stream 4 items back-to-back with `out_ready`=0 -> `in_ready` falls after item 2 is accepted. Raise `out_ready` -> all 4 items emerge in order on consecutive cycles.
- Random valid/ready toggling over 10k items, checked against a scoreboard computing `compress_shares` -> no loss, duplication or reordering.
- Assert `rst_n`=0 mid-stream for half a clock period -> `out_valid` and a..e are 0 immediately. After release, no stale item appears.
